pc_sequencer: RTL and testbench

- Owns the program counter for the single-cycle MIPS core and decides its next value every cycle.
- Sources for the next value, in priority order: reset, exception entry, ERET return, stall hold, redirect (JR/J/branch), sequential PC+4.
- Holds a pending-redirect latch so that a redirect arriving during a stall is not lost.
- Keeps the EPC register and an in-handler flag for exception sequencing.

---
 rtl/pc_sequencer.sv | 125 ++++++++++++
 tb/tb_pc_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program counter sequencer for the single-cycle MIPS core: next-PC selection, redirect
// pending latch across stalls, EPC and handler flag. Optional macro PC_RANGE_CHECK_EN traps out-of-range PCs.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h00003000,
  parameter logic [31:0] EXC_VECTOR = 32'h00004180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_offset,
  input  logic        j_en,
  input  logic [25:0] j_index,
  input  logic        jr_en,
  input  logic [31:0] jr_target,
  input  logic        exc_req,
  input  logic        eret,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] epc,
  output logic        in_exc,
  output logic        addr_err
);

`ifdef PC_RANGE_CHECK_EN
  localparam logic [31:0] PC_LO = 32'h00003000;
  localparam logic [31:0] PC_HI = 32'h00006FFC;
`endif

  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic        in_exc_q, in_exc_d;
  logic        addr_err_q, addr_err_d;
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;

  logic signed [31:0] br_disp;
  logic [31:0]        br_tgt, j_tgt, redir_tgt;
  logic               redir_vld, misalign, redir_ok;
  logic [31:0]        norm_pc;
  logic               norm_pend_vld, norm_in_exc, range_bad, take_exc;
  logic [31:0]        norm_pend_tgt;

  assign pc_plus4 = pc_q + 32'd4;
  assign br_disp  = {{14{br_offset[15]}}, br_offset, 2'b00};
  assign br_tgt   = pc_plus4 + $unsigned(br_disp);
  assign j_tgt    = {pc_plus4[31:28], j_index, 2'b00};

  assign redir_vld = jr_en | j_en | br_taken;
  assign redir_tgt = jr_en ? jr_target : (j_en ? j_tgt : br_tgt);
  assign misalign  = redir_vld & (redir_tgt[1:0] != 2'b00);
  // A misaligned target is never followed; inside the handler it is simply dropped.
  assign redir_ok  = redir_vld & ~misalign;

  always_comb begin
    norm_pc       = pc_q;
    norm_pend_vld = pend_vld_q;
    norm_pend_tgt = pend_tgt_q;
    norm_in_exc   = in_exc_q;
    if (eret && in_exc_q) begin
      norm_pc       = epc_q;
      norm_in_exc   = 1'b0;
      norm_pend_vld = 1'b0;
    end else if (stall) begin
      if (redir_ok) begin
        norm_pend_vld = 1'b1;
        norm_pend_tgt = redir_tgt;
      end
    end else if (redir_ok) begin
      norm_pc       = redir_tgt;
      norm_pend_vld = 1'b0;
    end else if (pend_vld_q) begin
      norm_pc       = pend_tgt_q;
      norm_pend_vld = 1'b0;
    end else begin
      norm_pc = pc_plus4;
    end
  end

`ifdef PC_RANGE_CHECK_EN
  assign range_bad = ~in_exc_q & ((norm_pc < PC_LO) | (norm_pc > PC_HI));
`else
  assign range_bad = 1'b0;
`endif

  assign take_exc = ~in_exc_q & (exc_req | misalign | range_bad);

  always_comb begin
    pc_d       = norm_pc;
    epc_d      = epc_q;
    in_exc_d   = norm_in_exc;
    pend_vld_d = norm_pend_vld;
    pend_tgt_d = norm_pend_tgt;
    addr_err_d = misalign | range_bad;
    if (take_exc) begin
      pc_d       = EXC_VECTOR;
      epc_d      = pc_q;
      in_exc_d   = 1'b1;
      pend_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      epc_q      <= 32'd0;
      in_exc_q   <= 1'b0;
      addr_err_q <= 1'b0;
      pend_vld_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      in_exc_q   <= in_exc_d;
      addr_err_q <= addr_err_d;
      pend_vld_q <= pend_vld_d;
    end
    pend_tgt_q <= pend_tgt_d;
  end

  assign pc       = pc_q;
  assign epc      = epc_q;
  assign in_exc   = in_exc_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios plus randomized traffic checked
// against a rule-level reference model; honours PC_RANGE_CHECK_EN when defined.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h00003000;
  localparam logic [31:0] EXC_PC = 32'h00004180;

  logic        clk = 1'b0;
  logic        reset, stall, br_taken, j_en, jr_en, exc_req, eret;
  logic [15:0] br_offset;
  logic [25:0] j_index;
  logic [31:0] jr_target;
  logic [31:0] pc, pc_plus4, epc;
  logic        in_exc, addr_err;

  pc_sequencer #(.RESET_PC(RST_PC), .EXC_VECTOR(EXC_PC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .br_offset(br_offset),
    .j_en(j_en), .j_index(j_index), .jr_en(jr_en), .jr_target(jr_target),
    .exc_req(exc_req), .eret(eret), .pc(pc), .pc_plus4(pc_plus4), .epc(epc),
    .in_exc(in_exc), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        in_exc;
    logic        addr_err;
  } exp_t;

  exp_t        sbq[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;

  // Reference model state
  logic [31:0] m_pc, m_epc;
  logic        m_inexc, m_aerr;
  logic [31:0] m_pend[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_update();
    logic [31:0] p4, tgt, nxt;
    logic rv, bad, enter, leave;
    int off;
    if (reset) begin
      m_pc = RST_PC; m_epc = 0; m_inexc = 0; m_aerr = 0;
      m_pend.delete();
      return;
    end
    p4  = m_pc + 4;
    off = $signed(br_offset);
    rv  = jr_en || j_en || br_taken;
    if (jr_en)     tgt = jr_target;
    else if (j_en) tgt = (p4 & 32'hF000_0000) | (32'(j_index) * 4);
    else           tgt = p4 + 32'(off * 4);
    bad    = rv && (tgt % 4 != 0);
    m_aerr = bad;
    enter  = !m_inexc && (exc_req || bad);
    leave  = 0;
    if (!enter) begin
      nxt = m_pc;
      if (eret && m_inexc) begin
        nxt = m_epc; leave = 1; m_pend.delete();
      end else if (stall) begin
        if (rv && !bad) begin m_pend.delete(); m_pend.push_back(tgt); end
      end else if (rv && !bad) begin
        nxt = tgt; m_pend.delete();
      end else if (m_pend.size() > 0) begin
        nxt = m_pend.pop_front();
      end else begin
        nxt = p4;
      end
`ifdef PC_RANGE_CHECK_EN
      if (!m_inexc && (nxt < 32'h3000 || nxt > 32'h6FFC)) begin
        enter = 1; m_aerr = 1;
      end
`endif
      if (!enter) begin
        m_pc = nxt;
        if (leave) m_inexc = 0;
      end
    end
    if (enter) begin
      m_epc = m_pc; m_pc = EXC_PC; m_inexc = 1; m_pend.delete();
    end
  endtask

  task automatic step();
    model_update();
    sbq.push_back('{cyc + 1, m_pc, m_epc, m_inexc, m_aerr});
    @(posedge clk); #1;
  endtask

  task automatic idle();
    reset = 0; stall = 0; br_taken = 0; br_offset = 0; j_en = 0; j_index = 0;
    jr_en = 0; jr_target = 0; exc_req = 0; eret = 0;
  endtask

  // Monitor: compare every due expectation against the DUT mid-cycle
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].due == cyc) begin
      exp_t e;
      e = sbq.pop_front();
      check("sb_pc", pc, e.pc);
      check("sb_pc_plus4", pc_plus4, e.pc + 32'd4);
      check("sb_epc", epc, e.epc);
      check("sb_in_exc", {31'd0, in_exc}, {31'd0, e.in_exc});
      check("sb_addr_err", {31'd0, addr_err}, {31'd0, e.addr_err});
    end
  end

  initial begin
    idle();
    reset = 1; step();
    check("rst_pc", pc, 32'h3000);
    check("rst_epc", epc, 32'h0);
    check("rst_in_exc", {31'd0, in_exc}, 32'd0);
    reset = 0;
    step(); check("seq1", pc, 32'h3004);
    step(); check("seq2", pc, 32'h3008);
    step(); check("seq3", pc, 32'h300C);
    step(); check("seq4", pc, 32'h3010);

    br_taken = 1; br_offset = 16'hFFFC; step(); idle();
    check("br_back", pc, 32'h3004);
    jr_en = 1; jr_target = 32'h3010; step(); idle();
    check("jr_3010", pc, 32'h3010);
    br_taken = 1; br_offset = 16'h0002; step(); idle();
    check("br_fwd", pc, 32'h301C);
    step(); check("seq5", pc, 32'h3020);

    stall = 1; j_en = 1; j_index = 26'h0000C10; step();
    check("stall1", pc, 32'h3020);
    j_en = 0; step(); check("stall2", pc, 32'h3020);
    step(); check("stall3", pc, 32'h3020);
    stall = 0; step(); check("pend_release", pc, 32'h3040);

    jr_en = 1; jr_target = 32'h3100; step(); idle();
    check("jr_3100", pc, 32'h3100);
    jr_en = 1; jr_target = 32'h3102; step(); idle();
    check("mis_pc", pc, 32'h4180);
    check("mis_aerr", {31'd0, addr_err}, 32'd1);
    check("mis_epc", epc, 32'h3100);
    check("mis_in_exc", {31'd0, in_exc}, 32'd1);
    step(); check("aerr_pulse", {31'd0, addr_err}, 32'd0);
    exc_req = 1; step(); idle();
    check("nest_pc", pc, 32'h4188);
    check("nest_epc", epc, 32'h3100);
    eret = 1; step(); idle();
    check("eret_pc", pc, 32'h3100);
    check("eret_in_exc", {31'd0, in_exc}, 32'd0);

    jr_en = 1; jr_target = 32'h3200; j_en = 1; j_index = 26'h0000C10;
    br_taken = 1; br_offset = 16'h0005; step(); idle();
    check("prio_pc", pc, 32'h3200);
    stall = 1; j_en = 1; j_index = 26'h0001000; step();
    check("stall_pend", pc, 32'h3200);
    j_en = 0; reset = 1; step(); idle();
    check("rst_mid_stall", pc, 32'h3000);
    step(); check("pend_aborted", pc, 32'h3004);

    jr_en = 1; jr_target = 32'h6FFC; step(); idle();
    check("jr_6ffc", pc, 32'h6FFC);
    step();
`ifdef PC_RANGE_CHECK_EN
    check("range_pc", pc, 32'h4180);
    check("range_epc", epc, 32'h6FFC);
`else
    check("range_off", pc, 32'h7000);
    jr_en = 1; jr_target = 32'hFFFF_FFFC; step(); idle();
    step(); check("wrap", pc, 32'h0);
`endif
    reset = 1; step(); idle();

    for (int i = 0; i < 600; i++) begin
      stall     = ($urandom_range(0, 3) == 0);
      br_taken  = ($urandom_range(0, 4) == 0);
      br_offset = 16'($urandom_range(0, 128)) - 16'd64;
      j_en      = ($urandom_range(0, 7) == 0);
      j_index   = 26'($urandom_range(32'h0C00, 32'h1BFF));
      jr_en     = ($urandom_range(0, 7) == 0);
      jr_target = (32'($urandom_range(32'h3000, 32'h6FFC)) & 32'hFFFF_FFFC)
                | (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
      exc_req   = ($urandom_range(0, 19) == 0);
      eret      = ($urandom_range(0, 5) == 0);
      reset     = ($urandom_range(0, 99) == 0);
      step();
    end
    idle();
    repeat (3) step();
    @(negedge clk); @(negedge clk);
    check("sb_drain", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
